dsm_interpolator: RTL and testbench
===================================

Name: dsm_interpolator

Overview:
- Transmit-direction counterpart of the ADC decimation path, for the on-chip test DAC.
- Accepts one low-rate 12-bit unsigned sample per OSR = 2^OSR_LOG2 clocks over a valid/ready handshake.
- Linearly interpolates between consecutive samples at full clock rate.
- Drives the interpolated word through a first-order digital delta-sigma modulator, producing a 1-bit stream for the DAC/loopback.

Parameters:
DATA_W, 12, sample width, unsigned
OSR_LOG2, 9, log2 of oversampling ratio (OSR = 512 clocks per input sample)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
in_data  in  DATA_W  low-rate sample, unsigned
in_valid  in  1  in_data valid
in_ready  out  1  block can accept a sample this cycle
out_data  out  DATA_W  interpolated high-rate word
bit_out  out  1  modulator bitstream
underrun  out  1  one-cycle pulse: segment ended with no sample queued

Behaviour:
- Reset (rst_n low at posedge) clears:
  - outputs: out_data=0, bit_out=0, underrun=0;
  - internal: state=IDLE, phase=0, prev=cur=nxt=0, nxt_valid=0, modulator acc=0;
  - in_ready reads 1 the cycle after reset.
- Reset mid-operation discards all queued and in-flight data; there is no flush.
- Input buffer: one-entry register nxt. in_ready = !nxt_valid, combinational from the flop.
  - Accept when in_valid && in_ready: nxt <= in_data, nxt_valid <= 1.
  - Holding in_valid high with in_ready low must not change nxt.
- States:
  - IDLE: phase frozen at 0, out_data held 0. When nxt_valid: prev <= nxt, cur <= nxt, nxt_valid <= 0, phase <= 0, go RUN.
  - RUN: phase increments every clock, mod OSR.
- RUN segment end, at the edge where phase == OSR-1 (phase wraps to 0):
  - nxt_valid=1: prev <= cur, cur <= nxt, nxt_valid <= 0.
  - nxt_valid=0: prev <= cur, cur unchanged (flat hold at last value); underrun <= 1 for one cycle.
  - A sample accepted on this same edge lands in nxt only and is used at the next segment end; underrun still fires.
- RUN never returns to IDLE except via reset.
- Interpolation, registered, one cycle latency from (prev, cur, phase):
  - out_data <= prev + floor(((cur - prev) * phase) / OSR).
  - The difference is signed DATA_W+1 bits; the product is signed DATA_W+1+OSR_LOG2 bits, arithmetic-shifted right by OSR_LOG2 (floor).
  - The result always lies between prev and cur, so it never wraps.
  - Implementation may use an incrementing accumulator instead of a multiplier, provided the results are bit-identical.
- Latency:
  - Sample accepted at edge E0 → RUN at E1 → out_data = sample from E2.
  - That first segment is flat.
- Modulator (first order, every clock, in IDLE too):
  - sum = {1'b0, acc} + {1'b0, out_data}, DATA_W+1 bits; acc <= sum[DATA_W-1:0]; bit_out <= sum[DATA_W].
  - Ones density = out_data / 2^DATA_W. out_data = 0 gives bit_out constantly 0.

Decomposition:
- Shared package: constants DATA_W and OSR_LOG2 defaults, the OSR value, state enum {IDLE, RUN}.
- Natural sub-module: dsm_mod1, holding the accumulator/carry modulator (parameter DATA_W; ports clk, rst_n, x, bit_out).
- Interpolator, handshake and state machine stay in the top.

Test Plan:
- Reset then idle 1000 cycles with in_valid=0 -> in_ready=1, out_data=0, bit_out=0, underrun=0 throughout.
- Send 2048, keep supplying 2048 each segment -> after 2-cycle latency out_data=2048 constant; bit_out alternates 1,0,… (density exactly 1/2); no underrun.
- Send 0, then 512 queued during first segment -> first 512 outputs are 0, next 512 outputs are 0,1,2,…,511, then 512 at the following segment start.
- Send 4095 then 0 -> descending segment 4095 - ceil(4095·p/512); check p=1 gives 4087, p=511 gives 7; no negative wrap.
- Backpressure: in_valid held high with changing data after the buffer fills -> in_ready=0 until the segment end; only the first queued value is used; later values are ignored until in_ready rises.
- Underrun: stop supplying after 1000 -> at the segment end underrun pulses exactly one cycle and out_data holds 1000 flat. Then assert rst_n low mid-segment -> next cycle all outputs 0, state IDLE, in_ready=1.

Source files
------------

// File: rtl/dsm_interpolator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsm_interpolator_pkg
// Purpose  : Shared constants and types for the test-DAC interpolator path.
//            Holds the default sample width and oversampling exponent, the
//            derived oversampling ratio, and the controller state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dsm_interpolator_pkg;

  localparam int DATA_W_DEFAULT   = 12;
  localparam int OSR_LOG2_DEFAULT = 9;
  localparam int OSR_DEFAULT      = 1 << OSR_LOG2_DEFAULT;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dsm_interpolator_mod1.sv
`default_nettype none
// ============================================================================
// Module   : dsm_mod1
// Purpose  : First-order digital delta-sigma modulator. The input word is
//            added into an accumulator every clock; the carry out of the add
//            is the output bit, so the ones density equals x / 2^DATA_W.
// Ports    : clk      - clock
//            rst_n    - synchronous active-low reset
//            x        - DATA_W-bit unsigned input word
//            bit_out  - registered 1-bit modulator stream
// Revision : 1.0 - initial release
// ============================================================================
module dsm_mod1
  import dsm_interpolator_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] x,
  output logic              bit_out
);

  logic [DATA_W-1:0] acc;
  logic [DATA_W:0]   sum;

  assign sum = {1'b0, acc} + {1'b0, x};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      bit_out <= 1'b0;
    end else begin
      acc     <= sum[DATA_W-1:0];
      bit_out <= sum[DATA_W];
    end
  end

endmodule
`default_nettype wire

// File: rtl/dsm_interpolator.sv
`default_nettype none
// ============================================================================
// Module   : dsm_interpolator
// Purpose  : Accepts one low-rate unsigned sample per OSR clocks over a
//            valid/ready handshake, linearly interpolates between consecutive
//            samples at full clock rate and feeds the result to a first-order
//            delta-sigma modulator for the on-chip test DAC.
// Ports    : clk       - clock
//            rst_n     - synchronous active-low reset
//            in_data   - low-rate sample (unsigned, DATA_W bits)
//            in_valid  - in_data valid
//            in_ready  - a sample can be accepted this cycle
//            out_data  - interpolated high-rate word
//            bit_out   - modulator bitstream
//            underrun  - one-cycle pulse: segment ended with no sample queued
// Revision : 1.0 - initial release
// ============================================================================
module dsm_interpolator
  import dsm_interpolator_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int OSR_LOG2 = OSR_LOG2_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              bit_out,
  output logic              underrun
);

  // Sign-extended difference times zero-extended phase; one spare bit on
  // each operand keeps the product width symmetric.
  localparam int PROD_W = DATA_W + OSR_LOG2 + 2;
  localparam logic [OSR_LOG2-1:0] PHASE_LAST = {OSR_LOG2{1'b1}};

  state_t              state;
  state_t              state_next;
  logic [OSR_LOG2-1:0] phase;
  logic [DATA_W-1:0]   prev;
  logic [DATA_W-1:0]   cur;
  logic [DATA_W-1:0]   nxt;
  logic                nxt_valid;
  logic                accept;
  logic                start;
  logic                seg_end;

  logic signed [DATA_W:0]   diff;
  logic signed [PROD_W-1:0] prod;
  logic [DATA_W-1:0]        offset;
  logic [DATA_W-1:0]        interp;

  assign in_ready = !nxt_valid;
  assign accept   = in_valid && !nxt_valid;

  // --------------------------------------------------------------------------
  // Controller
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    seg_end    = 1'b0;
    case (state)
      IDLE: begin
        if (nxt_valid) begin
          state_next = RUN;
          start      = 1'b1;
        end
      end
      RUN: begin
        seg_end = (phase == PHASE_LAST);
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Input buffer, segment bookkeeping and phase counter.
  // accept needs an empty buffer while start / segment-end consumption needs a
  // full one, so the two never collide on nxt_valid.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase     <= '0;
      prev      <= '0;
      cur       <= '0;
      nxt       <= '0;
      nxt_valid <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;

      if (accept) begin
        nxt       <= in_data;
        nxt_valid <= 1'b1;
      end

      if (start) begin
        prev      <= nxt;
        cur       <= nxt;
        nxt_valid <= 1'b0;
        phase     <= '0;
      end else if (state == RUN) begin
        phase <= phase + 1'b1;
        if (seg_end) begin
          prev <= cur;
          if (nxt_valid) begin
            cur       <= nxt;
            nxt_valid <= 1'b0;
          end else begin
            // Nothing queued: hold the last value flat for another segment.
            underrun <= 1'b1;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Interpolation: prev + floor((cur - prev) * phase / OSR).
  // The result always lies between prev and cur, so adding the low DATA_W bits
  // of the two's-complement offset modulo 2^DATA_W gives the exact value.
  // --------------------------------------------------------------------------
  always_comb begin
    diff   = $signed({1'b0, cur}) - $signed({1'b0, prev});
    prod   = $signed({{(OSR_LOG2 + 1){diff[DATA_W]}}, diff}) *
             $signed({{(DATA_W + 2){1'b0}}, phase});
    offset = DATA_W'(prod >>> OSR_LOG2);
    interp = prev + offset;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data <= '0;
    end else begin
      out_data <= (state == RUN) ? interp : '0;
    end
  end

  // --------------------------------------------------------------------------
  // Modulator runs every clock, including IDLE (where it sees zero).
  // --------------------------------------------------------------------------
  dsm_mod1 #(
    .DATA_W (DATA_W)
  ) u_mod (
    .clk     (clk),
    .rst_n   (rst_n),
    .x       (out_data),
    .bit_out (bit_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_dsm_interpolator.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsm_interpolator
// Purpose  : Self-checking bench for dsm_interpolator. Expected out_data words
//            are queued as each sample is sent and compared, one per clock, on
//            the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsm_interpolator;
  import dsm_interpolator_pkg::*;

  localparam int DW  = 12;
  localparam int OSR = 512;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          bit_out;
  logic          underrun;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int under_cnt = 0;
  bit mon_en = 1'b0;
  bit first = 1'b1;
  int last = 0;

  dsm_interpolator #(
    .DATA_W   (DW),
    .OSR_LOG2 (9)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .bit_out  (bit_out),
    .underrun (underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Linear interpolation from a to b at phase p, rounded towards a's floor.
  function automatic int exp_interp(input int a, input int b, input int p);
    if (b >= a) return a + ((b - a) * p) / OSR;
    else        return a - (((a - b) * p + OSR - 1) / OSR);
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (underrun) under_cnt++;
      if (exp_q.size() > 0) check("out_data", int'(out_data), exp_q.pop_front());
    end
  end

  // Applies reset for one edge and checks the state seen right after it.
  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    under_cnt = 0;
    check("rst_out_data", int'(out_data), 0);
    check("rst_bit_out", int'(bit_out), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_state", int'(dut.state), int'(IDLE));
    rst_n  = 1'b1;
    first  = 1'b1;
    mon_en = 1'b1;
  endtask

  // Sends one sample and queues the out_data words it determines.
  task automatic send(input int v);
    int waited = 0;
    while (!in_ready && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check("send_timeout", waited, 0);
      return;
    end
    in_data  = DW'(v);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (first) begin
      exp_q.push_back(0);
      exp_q.push_back(0);
      for (int p = 0; p < OSR; p++) exp_q.push_back(v);
      first = 1'b0;
    end else begin
      for (int p = 0; p < OSR; p++) exp_q.push_back(exp_interp(last, v, p));
    end
    last = v;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;

    // Idle after reset
    do_reset();
    for (int i = 0; i < 1000; i++) exp_q.push_back(0);
    repeat (1000) begin
      @(posedge clk); #1;
      check("idle_in_ready", int'(in_ready), 1);
      check("idle_bit_out", int'(bit_out), 0);
      check("idle_underrun", int'(underrun), 0);
    end

    // Constant mid-scale: density exactly 1/2
    do_reset();
    repeat (5) send(2048);
    check("const_no_underrun", under_cnt, 0);
    begin
      int pb;
      int ones;
      pb = int'(bit_out);
      ones = 0;
      repeat (64) begin
        @(posedge clk); #1;
        check("bit_alternate", int'(bit_out), 1 - pb);
        pb = int'(bit_out);
        ones += pb;
      end
      check("bit_density", ones, 32);
    end

    // Rising ramp 0 -> 512
    do_reset();
    send(0);
    send(512);
    send(512);
    check("ramp_no_underrun", under_cnt, 0);
    drain();

    // Full-scale descent 4095 -> 0
    do_reset();
    send(4095);
    send(0);
    check("desc_no_underrun", under_cnt, 0);
    drain();

    // Backpressure: junk offered while buffer is full must be ignored
    do_reset();
    send(100);
    send(3000);
    repeat (100) begin
      in_data  = DW'($urandom_range(0, 4095));
      in_valid = 1'b1;
      @(posedge clk); #1;
      check("bp_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    send(1500);
    check("bp_no_underrun", under_cnt, 0);
    drain();

    // Underrun then reset mid-segment
    do_reset();
    send(500);
    send(1000);
    for (int p = 0; p < OSR; p++) exp_q.push_back(1000);
    begin
      int n = 0;
      while (exp_q.size() > 200 && n < 3000) begin
        @(posedge clk); #1;
        n++;
      end
      check("underrun_wait", int'(exp_q.size() <= 200), 1);
    end
    check("underrun_count", under_cnt, 1);
    check("underrun_hold", int'(out_data), 1000);
    do_reset();
    for (int i = 0; i < 20; i++) exp_q.push_back(0);
    repeat (20) begin
      @(posedge clk); #1;
      check("post_rst_in_ready", int'(in_ready), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
